// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-port responder serving word RAM and MMIO regs.
// Ports: clk, rst(n), addr/wdata/mem_w in, rdata out, gpio_in/out, err.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
  parameter int unsigned GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_w,
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [5:0] OFF_CYCLE  = 6'h00;
  localparam logic [5:0] OFF_GPO    = 6'h01;
  localparam logic [5:0] OFF_GPI    = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_EADDR  = 6'h04;
  localparam logic [5:0] OFF_SCR    = 6'h05;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       cycle_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;
  logic [31:0]       scratch_q;
  logic [31:0]       eaddr_q;
  logic              err_q;

  logic              is_mmio;
  logic              is_ram;
  logic              aligned;
  logic              wr_ok;
  logic              fault;
  logic              mmio_we;
  logic              ram_we;
  logic [5:0]        off;
  logic [ADDR_W-1:0] idx;
  logic              cyc_ld;
  logic              gpo_ld;
  logic              scr_ld;
  logic              clr;
  logic [31:0]       mmio_rd;

  assign is_mmio = addr[31:8] == MMIO_BASE[31:8];
  assign is_ram  = addr[31:ADDR_W+2] == '0;
  assign aligned = addr[1:0] == 2'b00;
  assign off     = addr[7:2];
  assign idx     = addr[ADDR_W+1:2];

  assign wr_ok   = mem_w && aligned;
  assign fault   = mem_w && (!aligned || (!is_mmio && !is_ram));
  assign mmio_we = wr_ok && is_mmio;
  assign ram_we  = wr_ok && is_ram && !is_mmio;

  assign cyc_ld  = mmio_we && (off == OFF_CYCLE);
  assign gpo_ld  = mmio_we && (off == OFF_GPO);
  assign scr_ld  = mmio_we && (off == OFF_SCR);
  // W1C is not gated by fault: a coincident fault must see the clear
  // so that it re-captures ERR_ADDR.
  assign clr     = mmio_we && (off == OFF_STATUS) && wdata[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      gpio_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      scratch_q <= '0;
      eaddr_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      cycle_q <= cyc_ld ? wdata : cycle_q + 32'd1;
      if (gpo_ld) gpio_q <= wdata[GPIO_W-1:0];
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (scr_ld) scratch_q <= wdata;
      if (fault) err_q <= 1'b1;
      else if (clr) err_q <= 1'b0;
      if (fault && (!err_q || clr)) eaddr_q <= addr;
    end
  end

  // RAM has no reset; stores seen while rst is low are dropped.
  always_ff @(posedge clk) begin
    if (ram_we && rst) mem[idx] <= wdata;
  end

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_CYCLE:  mmio_rd = cycle_q;
      OFF_GPO:    mmio_rd[GPIO_W-1:0] = gpio_q;
      OFF_GPI:    mmio_rd[GPIO_W-1:0] = sync2_q;
      OFF_STATUS: mmio_rd[0] = err_q;
      OFF_EADDR:  mmio_rd = eaddr_q;
      OFF_SCR:    mmio_rd = scratch_q;
      default:    mmio_rd = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_mmio: rdata = mmio_rd;
      is_ram:  rdata = mem[idx];
      default: rdata = '0;
    endcase
  end

  assign gpio_out = gpio_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + randomized checks of dmem_responder
// against a word-level reference model of RAM, SCRATCH and error state.
module tb_dmem_responder;

  localparam logic [31:0] MB     = 32'hFFFF_FF00;
  localparam logic [31:0] A_CYC  = MB + 32'h00;
  localparam logic [31:0] A_GPO  = MB + 32'h04;
  localparam logic [31:0] A_GPI  = MB + 32'h08;
  localparam logic [31:0] A_STAT = MB + 32'h0C;
  localparam logic [31:0] A_EADR = MB + 32'h10;
  localparam logic [31:0] A_SCR  = MB + 32'h14;
  localparam logic [31:0] RBASE  = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_w = 1'b0;
  logic [31:0] rdata;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in = '0;
  logic        err;

  int checks = 0;
  int passes = 0;

  logic [31:0] ram_m [16];
  logic [31:0] scr_m;
  logic        err_m;
  logic [31:0] eaddr_m;

  dmem_responder #(
    .ADDR_W(10), .MMIO_BASE(MB), .GPIO_W(16)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mem_w(mem_w), .rdata(rdata), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    mem_w = 1'b1;
    cyc();
    mem_w = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    mem_w = 1'b0;
    #1;
    d = rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] d;
    int unsigned op;
    int unsigned w;

    // reset state
    #1;
    addr = A_CYC;
    #1;
    check("rst_cycle", rdata, 32'd0);
    check("rst_gpio", {16'd0, gpio_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    cyc();

    // counter from release
    rst = 1'b1;
    repeat (5) cyc();
    load(A_CYC, v);
    check("cycle_5", v, 32'd5);
    store(A_CYC, 32'hFFFF_FFFE);
    load(A_CYC, v);
    check("cycle_ld", v, 32'hFFFF_FFFE);
    cyc();
    load(A_CYC, v);
    check("cycle_max", v, 32'hFFFF_FFFF);
    cyc();
    load(A_CYC, v);
    check("cycle_wrap", v, 32'h0000_0000);

    // RAM word write/read
    store(32'h10, 32'h1111_1111);
    addr = 32'h10;
    wdata = 32'hDEAD_BEEF;
    mem_w = 1'b1;
    #1;
    check("ram_same_cyc", rdata, 32'h1111_1111);
    cyc();
    mem_w = 1'b0;
    load(32'h10, v);
    check("ram_rd", v, 32'hDEAD_BEEF);
    load(32'h13, v);
    check("ram_rd_13", v, 32'hDEAD_BEEF);

    // faulting stores
    store(32'h12, 32'h0000_CAFE);
    load(32'h10, v);
    check("flt_ram_kept", v, 32'hDEAD_BEEF);
    check("flt_err", {31'd0, err}, 32'd1);
    load(A_EADR, v);
    check("flt_eaddr", v, 32'h12);
    load(A_STAT, v);
    check("flt_status", v, 32'd1);
    store(32'h0001_0000, 32'h5);
    load(A_EADR, v);
    check("flt_eaddr_kept", v, 32'h12);
    store(A_STAT, 32'h1);
    check("w1c_err", {31'd0, err}, 32'd0);
    load(A_STAT, v);
    check("w1c_status", v, 32'd0);
    store(A_GPI, 32'hFFFF_FFFF);
    check("ro_no_err", {31'd0, err}, 32'd0);
    load(MB + 32'h40, v);
    check("undef_off", v, 32'd0);
    load(32'h0001_0000, v);
    check("unmapped_rd", v, 32'd0);

    // GPIO
    store(A_GPO, 32'h1234_A5A5);
    check("gpio_out", {16'd0, gpio_out}, 32'h0000_A5A5);
    load(A_GPO, v);
    check("gpio_rb", v, 32'h0000_A5A5);
    gpio_in = 16'h00F0;
    cyc();
    load(A_GPI, v);
    check("gpi_1", v, 32'd0);
    cyc();
    load(A_GPI, v);
    check("gpi_2", v, 32'h0000_00F0);

    // set/clear collision
    store(32'h2, 32'h0);
    load(A_EADR, v);
    check("col_pre", v, 32'h2);
    force dut.fault = 1'b1;
    store(A_STAT, 32'h1);
    release dut.fault;
    check("col_err", {31'd0, err}, 32'd1);
    load(A_EADR, v);
    check("col_eaddr", v, A_STAT);
    store(A_STAT, 32'h1);
    check("col_clr", {31'd0, err}, 32'd0);

    // randomized traffic against the model
    err_m = 1'b0;
    eaddr_m = '0;
    scr_m = '0;
    for (int i = 0; i < 16; i++) begin
      ram_m[i] = $urandom;
      store(RBASE + 32'(i * 4), ram_m[i]);
    end
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      a = RBASE + 32'(w * 4);
      d = $urandom;
      if (op < 3) begin
        store(a, d);
        ram_m[w] = d;
      end else if (op < 6) begin
        load(a | 32'($urandom_range(0, 3)), v);
        check("rnd_ram", v, ram_m[w]);
      end else if (op == 6) begin
        store(A_SCR, d);
        scr_m = d;
      end else if (op == 7) begin
        load(A_SCR, v);
        check("rnd_scr", v, scr_m);
      end else if (op == 8) begin
        a = a | 32'($urandom_range(1, 3));
        store(a, d);
        if (!err_m) eaddr_m = a;
        err_m = 1'b1;
      end else begin
        check("rnd_err", {31'd0, err}, {31'd0, err_m});
      end
    end
    check("rnd_err_end", {31'd0, err}, {31'd0, err_m});
    if (err_m) begin
      load(A_EADR, v);
      check("rnd_eaddr", v, eaddr_m);
    end

    // reset mid-operation
    store(A_GPO, 32'h0000_FFFF);
    store(32'h1, 32'h0);
    check("pre_rst_err", {31'd0, err}, 32'd1);
    addr = A_CYC;
    #1;
    rst = 1'b0;
    #1;
    check("arst_gpio", {16'd0, gpio_out}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_cycle", rdata, 32'd0);
    addr = RBASE;
    wdata = ~ram_m[0];
    mem_w = 1'b1;
    cyc();
    cyc();
    mem_w = 1'b0;
    rst = 1'b1;
    load(RBASE, v);
    check("arst_ram", v, ram_m[0]);
    load(A_SCR, v);
    check("arst_scr", v, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
